draw_ball: RTL and testbench

//  Pipeline stage directly downstream of the background stage. Consumes its vga_intf stream,

---
 rtl/pong_pkg.sv | 9 +
 rtl/vga_pkg.sv | 5 +
 rtl/ball_ctl.sv | 133 +++++++++++++
 rtl/draw_ball.sv | 78 +++++++
 tb/tb_draw_ball.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Pong game types and paddle geometry shared by draw_ball and draw_paddle.
package pong_pkg;
    typedef enum logic [1:0] {SERVE, MOVE, SCORE} ball_state_t;

    localparam int PADDLE_W   = 12;
    localparam int PADDLE_H   = 96;
    localparam int PADDLE_X_L = 32;
    localparam int PADDLE_X_R = vga_pkg::HOR_PIXELS - 32 - PADDLE_W;
endpackage

// File: rtl/vga_pkg.sv
// VGA frame geometry shared by every stage of the video pipeline.
package vga_pkg;
    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;
endpackage

// File: rtl/ball_ctl.sv
// Ball motion: per-frame serve/move/score FSM with wall and paddle collisions.
// `BALL_SPEEDUP_EN: each paddle hit raises |dx| by one, capped at MAX_DX.
import vga_pkg::*;
import pong_pkg::*;

module ball_ctl #(
    parameter int BALL_SIZE    = 16,
    parameter int INIT_DX      = 4,
    parameter int INIT_DY      = 3,
    parameter int MAX_DX       = 12,
    parameter int PADDLE_X_L   = pong_pkg::PADDLE_X_L,
    parameter int PADDLE_W     = pong_pkg::PADDLE_W,
    parameter int PADDLE_H     = pong_pkg::PADDLE_H,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_en,
    input  logic               vblnk,
    input  logic [10:0]        paddle_l_y,
    input  logic [10:0]        paddle_r_y,
    output logic signed [11:0] x,
    output logic signed [11:0] y,
    output logic               visible,
    output logic               score_l,
    output logic               score_r
);
    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam logic signed [11:0] X_C   = 12'(HOR_PIXELS / 2 - BALL_SIZE / 2);
    localparam logic signed [11:0] Y_C   = 12'(VER_PIXELS / 2 - BALL_SIZE / 2);
    localparam logic signed [11:0] X_MAX = 12'(HOR_PIXELS - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX = 12'(VER_PIXELS - BALL_SIZE);
    localparam logic signed [11:0] LX    = 12'(PADDLE_X_L + PADDLE_W);
    localparam logic signed [11:0] RX    = 12'(HOR_PIXELS - 32 - PADDLE_W - BALL_SIZE);
    localparam logic signed [11:0] IDX   = 12'(INIT_DX);
    localparam logic signed [11:0] IDY   = 12'(INIT_DY);
    localparam logic signed [11:0] MDX   = 12'(MAX_DX);
`ifdef BALL_SPEEDUP_EN
    localparam logic signed [11:0] DX_STEP = 12'sd1;
`else
    localparam logic signed [11:0] DX_STEP = 12'sd0;
`endif

    ball_state_t        state;
    logic [CW-1:0]      frame_cnt;
    logic signed [11:0] dx, dy, nx, ny, adx, ady, hit_dx;
    logic               vblnk_d, tick, ovl_l, ovl_r, hit_l, hit_r;

    assign tick    = vblnk & ~vblnk_d;
    assign visible = (state != SCORE);
    assign nx      = x + dx;
    assign ny      = y + dy;
    assign adx     = (dx < 0) ? -dx : dx;
    assign ady     = (dy < 0) ? -dy : dy;
    // With speed-up disabled DX_STEP is zero and the cap never engages.
    assign hit_dx  = (DX_STEP != 0 && adx >= MDX) ? MDX : adx + DX_STEP;

    assign ovl_l = (int'(y) < int'(paddle_l_y) + PADDLE_H) && (int'(y) + BALL_SIZE > int'(paddle_l_y));
    assign ovl_r = (int'(y) < int'(paddle_r_y) + PADDLE_H) && (int'(y) + BALL_SIZE > int'(paddle_r_y));
    assign hit_l = (dx < 0) && (nx <= LX) && (x >= LX) && ovl_l;
    assign hit_r = (dx > 0) && (nx >= RX) && (x <= RX) && ovl_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SERVE;
            frame_cnt <= '0;
            x         <= X_C;
            y         <= Y_C;
            dx        <= IDX;
            dy        <= IDY;
            vblnk_d   <= 1'b0;
            score_l   <= 1'b0;
            score_r   <= 1'b0;
        end else begin
            vblnk_d <= vblnk;
            score_l <= 1'b0;
            score_r <= 1'b0;
            if (!game_en) begin
                state     <= SERVE;
                frame_cnt <= '0;
                x         <= X_C;
                y         <= Y_C;
            end else if (tick) begin
                case (state)
                    SERVE: begin
                        if (frame_cnt == CW'(SERVE_FRAMES - 1)) begin
                            state     <= MOVE;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + CW'(1);
                        end
                    end
                    MOVE: begin
                        if (ny <= 0) begin
                            y  <= '0;
                            dy <= ady;
                        end else if (ny >= Y_MAX) begin
                            y  <= Y_MAX;
                            dy <= -ady;
                        end else begin
                            y  <= ny;
                        end
                        // Serve velocity is loaded at exit; the ball is hidden until re-centred.
                        if (hit_l) begin
                            x  <= LX;
                            dx <= hit_dx;
                        end else if (hit_r) begin
                            x  <= RX;
                            dx <= -hit_dx;
                        end else if (nx < 0) begin
                            score_r <= 1'b1;
                            state   <= SCORE;
                            dx      <= -IDX;
                            dy      <= IDY;
                        end else if (nx > X_MAX) begin
                            score_l <= 1'b1;
                            state   <= SCORE;
                            dx      <= IDX;
                            dy      <= IDY;
                        end else begin
                            x <= nx;
                        end
                    end
                    default: begin
                        state <= SERVE;
                        x     <= X_C;
                        y     <= Y_C;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/draw_ball.sv
// Ball overlay stage: registers the VGA stream with 1 clk latency and paints the ball.
// `BALL_SPEEDUP_EN enables paddle-hit speed-up inside ball_ctl.
import vga_pkg::*;
import pong_pkg::*;

module draw_ball #(
    parameter int          BALL_SIZE    = 16,
    parameter logic [11:0] BALL_COLOR   = 12'hfff,
    parameter int          INIT_DX      = 4,
    parameter int          INIT_DY      = 3,
    parameter int          MAX_DX       = 12,
    parameter int          PADDLE_X_L   = pong_pkg::PADDLE_X_L,
    parameter int          PADDLE_W     = pong_pkg::PADDLE_W,
    parameter int          PADDLE_H     = pong_pkg::PADDLE_H,
    parameter int          SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_en,
    input  logic [10:0] paddle_l_y,
    input  logic [10:0] paddle_r_y,
    input  logic [10:0] bg_vcount,
    input  logic        bg_vsync,
    input  logic        bg_vblnk,
    input  logic [10:0] bg_hcount,
    input  logic        bg_hsync,
    input  logic        bg_hblnk,
    input  logic [11:0] bg_rgb,
    output logic [10:0] ball_vcount,
    output logic        ball_vsync,
    output logic        ball_vblnk,
    output logic [10:0] ball_hcount,
    output logic        ball_hsync,
    output logic        ball_hblnk,
    output logic [11:0] ball_rgb,
    output logic        score_l,
    output logic        score_r
);
    localparam logic signed [11:0] BS = 12'(BALL_SIZE);

    logic signed [11:0] bx, by, hc, vc;
    logic               visible, in_box;

    ball_ctl #(
        .BALL_SIZE(BALL_SIZE), .INIT_DX(INIT_DX), .INIT_DY(INIT_DY), .MAX_DX(MAX_DX),
        .PADDLE_X_L(PADDLE_X_L), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H),
        .SERVE_FRAMES(SERVE_FRAMES)
    ) u_ctl (
        .clk(clk), .rst(rst), .game_en(game_en), .vblnk(bg_vblnk),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .x(bx), .y(by), .visible(visible), .score_l(score_l), .score_r(score_r)
    );

    assign hc     = $signed({1'b0, bg_hcount});
    assign vc     = $signed({1'b0, bg_vcount});
    assign in_box = visible && !bg_hblnk && !bg_vblnk &&
                    (hc >= bx) && (hc < bx + BS) && (vc >= by) && (vc < by + BS);

    always_ff @(posedge clk) begin
        if (rst) begin
            ball_vcount <= '0;
            ball_vsync  <= 1'b0;
            ball_vblnk  <= 1'b0;
            ball_hcount <= '0;
            ball_hsync  <= 1'b0;
            ball_hblnk  <= 1'b0;
            ball_rgb    <= '0;
        end else begin
            ball_vcount <= bg_vcount;
            ball_vsync  <= bg_vsync;
            ball_vblnk  <= bg_vblnk;
            ball_hcount <= bg_hcount;
            ball_hsync  <= bg_hsync;
            ball_hblnk  <= bg_hblnk;
            ball_rgb    <= in_box ? BALL_COLOR : bg_rgb;
        end
    end
endmodule

// File: tb/tb_draw_ball.sv
// Randomized scoreboard bench for draw_ball using compressed synthetic frames.
module tb_draw_ball;
    localparam int SF = 2;

    logic        clk = 1'b0;
    logic        rst, game_en;
    logic [10:0] paddle_l_y, paddle_r_y, bg_vcount, bg_hcount;
    logic        bg_vsync, bg_vblnk, bg_hsync, bg_hblnk;
    logic [11:0] bg_rgb;
    logic [10:0] ball_vcount, ball_hcount;
    logic        ball_vsync, ball_vblnk, ball_hsync, ball_hblnk;
    logic [11:0] ball_rgb;
    logic        score_l, score_r;

    draw_ball #(.SERVE_FRAMES(SF)) dut (
        .clk(clk), .rst(rst), .game_en(game_en),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .bg_vcount(bg_vcount), .bg_vsync(bg_vsync), .bg_vblnk(bg_vblnk),
        .bg_hcount(bg_hcount), .bg_hsync(bg_hsync), .bg_hblnk(bg_hblnk), .bg_rgb(bg_rgb),
        .ball_vcount(ball_vcount), .ball_vsync(ball_vsync), .ball_vblnk(ball_vblnk),
        .ball_hcount(ball_hcount), .ball_hsync(ball_hsync), .ball_hblnk(ball_hblnk),
        .ball_rgb(ball_rgb), .score_l(score_l), .score_r(score_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int stamp; logic [39:0] v; } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;

    // Reference ball: 0 = serve, 1 = move, 2 = score
    int ms, mx, my, mdx, mdy, mcnt;
    bit mprev;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step(input bit r, input bit en, input bit vb, output bit sl, output bit sr);
        int nx, ny, oy, pl, pr, spd;
        bit tick, hl, hr;
        sl = 0; sr = 0;
        if (r) begin
            ms = 0; mx = 504; my = 376; mdx = 4; mdy = 3; mcnt = 0; mprev = 0;
            return;
        end
        tick = vb && !mprev;
        mprev = vb;
        if (!en) begin
            ms = 0; mx = 504; my = 376; mcnt = 0;
        end else if (tick) begin
            if (ms == 0) begin
                if (mcnt == SF - 1) begin ms = 1; mcnt = 0; end
                else mcnt++;
            end else if (ms == 2) begin
                ms = 0; mx = 504; my = 376;
            end else begin
                nx = mx + mdx; ny = my + mdy; oy = my;
                pl = int'(paddle_l_y); pr = int'(paddle_r_y);
`ifdef BALL_SPEEDUP_EN
                spd = (iabs(mdx) + 1 > 12) ? 12 : iabs(mdx) + 1;
`else
                spd = iabs(mdx);
`endif
                if (ny <= 0) begin my = 0; mdy = iabs(mdy); end
                else if (ny >= 752) begin my = 752; mdy = -iabs(mdy); end
                else my = ny;
                hl = mdx < 0 && nx <= 44 && mx >= 44 && oy < pl + 96 && oy + 16 > pl;
                hr = mdx > 0 && nx + 16 >= 980 && mx + 16 <= 980 && oy < pr + 96 && oy + 16 > pr;
                if (hl) begin mx = 44; mdx = spd; end
                else if (hr) begin mx = 964; mdx = -spd; end
                else if (nx < 0) begin sr = 1; ms = 2; mdx = -4; mdy = 3; end
                else if (nx > 1008) begin sl = 1; ms = 2; mdx = 4; mdy = 3; end
                else mx = nx;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit en, input bit vb, input int hc, input int vc, input bit hb);
        logic [10:0] h11, v11;
        logic [11:0] rgb;
        bit vs, hs, sl, sr, inbox;
        exp_t e;
        h11 = 11'((hc < 0) ? 0 : (hc > 2047 ? 2047 : hc));
        v11 = 11'((vc < 0) ? 0 : (vc > 2047 ? 2047 : vc));
        vs = 1'($urandom); hs = 1'($urandom); rgb = 12'($urandom);
        rst = r; game_en = en; bg_vblnk = vb; bg_hblnk = hb;
        bg_hcount = h11; bg_vcount = v11; bg_vsync = vs; bg_hsync = hs; bg_rgb = rgb;
        inbox = ms != 2 && !hb && !vb && int'(h11) >= mx && int'(h11) < mx + 16 &&
                int'(v11) >= my && int'(v11) < my + 16;
        model_step(r, en, vb, sl, sr);
        if (r) e.v = '0;
        else e.v = {v11, vs, vb, h11, hs, hb, inbox ? 12'hfff : rgb, sl, sr};
        e.stamp = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        exp_t e;
        logic [39:0] got;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].stamp <= cyc) begin
                e = q.pop_front();
                got = {ball_vcount, ball_vsync, ball_vblnk, ball_hcount, ball_hsync,
                       ball_hblnk, ball_rgb, score_l, score_r};
                n_cmp++;
                if (got !== e.v) begin
                    n_bad++;
                    $display("FAIL out cyc=%0d got=%h want=%h (rgb %h/%h score %b/%b)",
                             cyc, got, e.v, got[13:2], e.v[13:2], got[1:0], e.v[1:0]);
                end
            end
        end
    end

    initial begin
        rst = 1; game_en = 1; paddle_l_y = '0; paddle_r_y = '0;
        bg_vcount = '0; bg_hcount = '0; bg_vsync = 0; bg_vblnk = 0;
        bg_hsync = 0; bg_hblnk = 0; bg_rgb = '0;
        ms = 0; mx = 504; my = 376; mdx = 4; mdy = 3; mcnt = 0; mprev = 0;
        @(posedge clk); #1;
        repeat (3) cycle(1, 1, 0, 504, 376, 0);
        for (int f = 0; f < 700; f++) begin
            // Half the frames the paddles track the ball, otherwise they sit far away.
            if ($urandom_range(0, 1) == 1) begin
                paddle_l_y = 11'((my - int'($urandom_range(0, 90)) < 0) ? 0 : my - int'($urandom_range(0, 90)));
                paddle_r_y = 11'((my - int'($urandom_range(0, 90)) < 0) ? 0 : my - int'($urandom_range(0, 90)));
            end else begin
                paddle_l_y = 11'((my + 400) % 700);
                paddle_r_y = 11'((my + 450) % 700);
            end
            repeat (2) cycle(0, 1, 1, int'($urandom_range(0, 1100)), int'($urandom_range(0, 800)), 1'($urandom));
            for (int p = 0; p < 12; p++) begin
                cycle((f == 150 && p == 5) || (f == 420 && p == 3),
                      !((f == 260 || f == 560) && (p == 4 || p == 5)), 0,
                      mx + int'($urandom_range(0, 22)) - 3,
                      my + int'($urandom_range(0, 22)) - 3,
                      $urandom_range(0, 7) == 0);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
